// File: rtl/turf_readout_pkg.sv
// Shared types and helpers for the TURF event readout sequencer.
package turf_readout_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        TIO    = 2'd2
    } rd_state_e;

    localparam int          HDR_QWORDS_DEF = 16;
    localparam int          NUM_TIO_DEF    = 4;
    localparam logic [15:0] TIMEOUT_MARKER = 16'hDEAD;

    // Masks are widened to MAX_TIO (padding bits excluded) so one helper serves any NUM_TIO.
    localparam int MAX_TIO   = 16;
    localparam int MAX_TIO_W = 4;

    typedef struct packed {
        logic                 none;
        logic [MAX_TIO_W-1:0] idx;
    } tio_pick_t;

    // Lowest index >= start whose mask bit is 0; none=1 if no such index exists.
    function automatic tio_pick_t next_unmasked(input logic [MAX_TIO-1:0] mask, input int start);
        tio_pick_t r;
        r.none = 1'b1;
        r.idx  = '0;
        for (int i = MAX_TIO - 1; i >= 0; i--) begin
            if ((i >= start) && !mask[i]) begin
                r.none = 1'b0;
                r.idx  = MAX_TIO_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/turf_axis_skid64.sv
// Two-entry AXI4-Stream output register: one-cycle latency, full throughput,
// upstream ready is registered so it never depends combinationally on downstream ready.
module turf_axis_skid64 #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic                  l0_q, l0_d, l1_q, l1_d;
    logic                  rdy_q, rdy_d;
    logic                  push, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            d0_q  <= '0;
            d1_q  <= '0;
            l0_q  <= 1'b0;
            l1_q  <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            l0_q  <= l0_d;
            l1_q  <= l1_d;
            rdy_q <= rdy_d;
        end
    end

    always_comb begin
        push  = in_valid & rdy_q;
        pop   = (cnt_q != 2'd0) & out_ready;
        cnt_d = cnt_q;
        d0_d  = d0_q;
        d1_d  = d1_q;
        l0_d  = l0_q;
        l1_d  = l1_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    d0_d  = in_data;
                    l0_d  = in_last;
                    cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    d0_d = in_data;
                    l0_d = in_last;
                end else if (push) begin
                    d1_d  = in_data;
                    l1_d  = in_last;
                    cnt_d = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    d0_d  = d1_q;
                    l0_d  = l1_q;
                    cnt_d = 2'd1;
                end
            end
        endcase
        // Held as a flop so ready reads 0 while reset is asserted.
        rdy_d = (cnt_d != 2'd2);
    end

    assign in_ready  = rdy_q;
    assign out_data  = d0_q;
    assign out_last  = l0_q;
    assign out_valid = (cnt_q != 2'd0);

endmodule

// File: rtl/turf_event_readout_ctrl.sv
// Event readout sequencer: TURF header, then each enabled TURFIO fragment, as one AXI4-Stream event.
// Optional stall timeout with marker injection: define TURF_READOUT_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for first header qword; mask latched when it is accepted
// HEADER | forwarding remaining header qwords
// TIO    | draining TURFIO stream sel_q until its tlast (or timeout)
module turf_event_readout_ctrl
    import turf_readout_pkg::*;
#(
    parameter int NUM_TIO    = NUM_TIO_DEF,
    parameter int HDR_QWORDS = HDR_QWORDS_DEF,
    parameter int DATA_WIDTH = 64
`ifdef TURF_READOUT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_BITS = 16
`endif
) (
    input  logic                          memclk,
    input  logic                          memresetn,
    input  logic [DATA_WIDTH-1:0]         s_thdr_tdata,
    input  logic                          s_thdr_tvalid,
    output logic                          s_thdr_tready,
    input  logic [NUM_TIO*DATA_WIDTH-1:0] s_tio_tdata,
    input  logic [NUM_TIO-1:0]            s_tio_tvalid,
    input  logic [NUM_TIO-1:0]            s_tio_tlast,
    output logic [NUM_TIO-1:0]            s_tio_tready,
    input  logic [NUM_TIO-1:0]            tio_mask_i,
    output logic [DATA_WIDTH-1:0]         m_ev_tdata,
    output logic                          m_ev_tvalid,
    output logic                          m_ev_tlast,
    input  logic                          m_ev_tready,
    output logic                          event_done_o,
    output logic                          busy_o
`ifdef TURF_READOUT_TIMEOUT_EN
    ,
    input  logic [TIMEOUT_BITS-1:0]       timeout_i,
    output logic [NUM_TIO-1:0]            tio_timeout_o
`endif
);

    localparam int SEL_W     = (NUM_TIO > 1) ? $clog2(NUM_TIO) : 1;
    localparam int HDR_CNT_W = $clog2(HDR_QWORDS + 1);

    rd_state_e              state_q, state_d;
    logic [HDR_CNT_W-1:0]   hdr_cnt_q, hdr_cnt_d;
    logic [NUM_TIO-1:0]     mask_q, mask_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [1:0]             inflight_q, inflight_d;
    logic                   done_q, done_d;

    logic [MAX_TIO-1:0]     mask_ext_in, mask_ext_q;
    tio_pick_t              first_sel, adv_sel;
    logic                   hdr_last_beat;

    logic [DATA_WIDTH-1:0]  sk_data;
    logic                   sk_last, sk_valid, sk_ready;
    logic                   hdr_push, tio_push, tmo_fire, seg_end, ev_hs;

`ifdef TURF_READOUT_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [NUM_TIO-1:0]      tio_timeout_q, tio_timeout_d;
    logic                    tmo_hit;

    assign tmo_hit       = (timeout_i != '0) && (tmo_cnt_q == timeout_i);
    assign tio_timeout_o = tio_timeout_q;
`endif

    always_comb begin
        mask_ext_in              = '1;
        mask_ext_in[NUM_TIO-1:0] = tio_mask_i;
        mask_ext_q               = '1;
        mask_ext_q[NUM_TIO-1:0]  = mask_q;
    end

    // In IDLE the header beat being accepted is the one that latches the mask.
    assign first_sel     = next_unmasked((state_q == IDLE) ? mask_ext_in : mask_ext_q, 0);
    assign adv_sel       = next_unmasked(mask_ext_q, int'(sel_q) + 1);
    assign hdr_last_beat = (hdr_cnt_q == HDR_CNT_W'(HDR_QWORDS - 1));

    always_ff @(posedge memclk or negedge memresetn) begin
        if (!memresetn) begin
            state_q    <= IDLE;
            hdr_cnt_q  <= '0;
            mask_q     <= '0;
            sel_q      <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
`ifdef TURF_READOUT_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            tio_timeout_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            mask_q     <= mask_d;
            sel_q      <= sel_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
`ifdef TURF_READOUT_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            tio_timeout_q <= tio_timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        mask_d    = mask_q;
        sel_d     = sel_q;
        case (state_q)
            IDLE, HEADER: begin
                if (hdr_push) begin
                    if (state_q == IDLE) begin
                        mask_d = tio_mask_i;
                    end
                    hdr_cnt_d = hdr_cnt_q + HDR_CNT_W'(1);
                    if (!hdr_last_beat) begin
                        state_d = HEADER;
                    end else if (first_sel.none) begin
                        state_d   = IDLE;
                        hdr_cnt_d = '0;
                    end else begin
                        state_d = TIO;
                        sel_d   = SEL_W'(first_sel.idx);
                    end
                end
            end
            TIO: begin
                if (seg_end) begin
                    if (adv_sel.none) begin
                        state_d   = IDLE;
                        hdr_cnt_d = '0;
                    end else begin
                        sel_d = SEL_W'(adv_sel.idx);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                hdr_cnt_d = '0;
            end
        endcase

        ev_hs      = m_ev_tvalid & m_ev_tready & m_ev_tlast;
        done_d     = ev_hs;
        inflight_d = inflight_q + 2'((state_q == IDLE) & hdr_push) - 2'(ev_hs);

`ifdef TURF_READOUT_TIMEOUT_EN
        tmo_cnt_d     = '0;
        tio_timeout_d = tio_timeout_q;
        if (state_q == TIO) begin
            if (tio_push || tmo_fire) begin
                tmo_cnt_d = '0;
            end else if (!s_tio_tvalid[sel_q] && !tmo_hit) begin
                tmo_cnt_d = tmo_cnt_q + TIMEOUT_BITS'(1);
            end else begin
                tmo_cnt_d = tmo_cnt_q;
            end
        end
        if (tmo_fire) begin
            tio_timeout_d[sel_q] = 1'b1;
        end
`endif
    end

    always_comb begin
        s_thdr_tready = 1'b0;
        s_tio_tready  = '0;
        sk_valid      = 1'b0;
        sk_data       = s_thdr_tdata;
        sk_last       = 1'b0;
        hdr_push      = 1'b0;
        tio_push      = 1'b0;
        tmo_fire      = 1'b0;
        case (state_q)
            IDLE, HEADER: begin
                s_thdr_tready = sk_ready;
                sk_valid      = s_thdr_tvalid;
                sk_last       = hdr_last_beat & first_sel.none;
                hdr_push      = s_thdr_tvalid & sk_ready;
            end
            TIO: begin
`ifdef TURF_READOUT_TIMEOUT_EN
                if (tmo_hit) begin
                    sk_valid = 1'b1;
                    sk_data  = {TIMEOUT_MARKER, 8'(sel_q), 40'h0};
                    sk_last  = adv_sel.none;
                    tmo_fire = sk_ready;
                end else begin
                    s_tio_tready[sel_q] = sk_ready;
                    sk_valid            = s_tio_tvalid[sel_q];
                    sk_data             = s_tio_tdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
                    sk_last             = s_tio_tlast[sel_q] & adv_sel.none;
                    tio_push            = s_tio_tvalid[sel_q] & sk_ready;
                end
`else
                s_tio_tready[sel_q] = sk_ready;
                sk_valid            = s_tio_tvalid[sel_q];
                sk_data             = s_tio_tdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
                sk_last             = s_tio_tlast[sel_q] & adv_sel.none;
                tio_push            = s_tio_tvalid[sel_q] & sk_ready;
`endif
            end
            default: ;
        endcase
        // Fragment tlasts are consumed here; only the final one reaches the event stream.
        seg_end = (tio_push & s_tio_tlast[sel_q]) | tmo_fire;
    end

    turf_axis_skid64 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_skid (
        .clk       (memclk),
        .rst_n     (memresetn),
        .in_data   (sk_data),
        .in_last   (sk_last),
        .in_valid  (sk_valid),
        .in_ready  (sk_ready),
        .out_data  (m_ev_tdata),
        .out_last  (m_ev_tlast),
        .out_valid (m_ev_tvalid),
        .out_ready (m_ev_tready)
    );

    assign event_done_o = done_q;
    assign busy_o       = (inflight_q != 2'd0);

endmodule

// File: tb/tb_turf_event_readout_ctrl.sv
// Directed bench for turf_event_readout_ctrl; timeout case active when TURF_READOUT_TIMEOUT_EN is defined.
module tb_turf_event_readout_ctrl;

    localparam int NT = 4;

    typedef struct packed {
        logic        last;
        logic [63:0] d;
    } beat_t;

    logic            memclk = 1'b0;
    logic            memresetn = 1'b0;
    logic [63:0]     s_thdr_tdata;
    logic            s_thdr_tvalid;
    logic            s_thdr_tready;
    logic [NT*64-1:0] s_tio_tdata;
    logic [NT-1:0]   s_tio_tvalid;
    logic [NT-1:0]   s_tio_tlast;
    logic [NT-1:0]   s_tio_tready;
    logic [NT-1:0]   tio_mask_i;
    logic [63:0]     m_ev_tdata;
    logic            m_ev_tvalid;
    logic            m_ev_tlast;
    logic            m_ev_tready;
    logic            event_done_o;
    logic            busy_o;
`ifdef TURF_READOUT_TIMEOUT_EN
    logic [15:0]     timeout_i;
    logic [NT-1:0]   tio_timeout_o;
`endif

    logic [63:0] hdr_q[$];
    beat_t       tio_q[NT][$];
    beat_t       exp_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   oh_err = 0;
    int   tio_rdy_seen = 0;
    int   d0;
    int   r0;
    logic rdy_rand = 1'b0;

    always #5 memclk = ~memclk;

    turf_event_readout_ctrl dut (
        .memclk        (memclk),
        .memresetn     (memresetn),
        .s_thdr_tdata  (s_thdr_tdata),
        .s_thdr_tvalid (s_thdr_tvalid),
        .s_thdr_tready (s_thdr_tready),
        .s_tio_tdata   (s_tio_tdata),
        .s_tio_tvalid  (s_tio_tvalid),
        .s_tio_tlast   (s_tio_tlast),
        .s_tio_tready  (s_tio_tready),
        .tio_mask_i    (tio_mask_i),
        .m_ev_tdata    (m_ev_tdata),
        .m_ev_tvalid   (m_ev_tvalid),
        .m_ev_tlast    (m_ev_tlast),
        .m_ev_tready   (m_ev_tready),
        .event_done_o  (event_done_o),
`ifdef TURF_READOUT_TIMEOUT_EN
        .busy_o        (busy_o),
        .timeout_i     (timeout_i),
        .tio_timeout_o (tio_timeout_o)
`else
        .busy_o        (busy_o)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue one event; silent streams send nothing and are expected to be replaced by a marker.
    task automatic send_event(input logic [63:0] hbase, input logic [63:0] tbase,
                              input logic [NT-1:0] mask, input int nb, input logic [NT-1:0] silent);
        int hi;
        beat_t b;
        hi = -1;
        for (int i = 0; i < NT; i++) if (!mask[i]) hi = i;
        for (int k = 0; k < 16; k++) begin
            hdr_q.push_back(hbase + 64'(k));
            b.d = hbase + 64'(k);
            b.last = (k == 15) && (hi < 0);
            exp_q.push_back(b);
        end
        for (int i = 0; i < NT; i++) begin
            if (!mask[i] && silent[i]) begin
                b.d = {16'hDEAD, 8'(i), 40'h0};
                b.last = (i == hi);
                exp_q.push_back(b);
            end else if (!mask[i]) begin
                for (int k = 0; k < nb; k++) begin
                    b.d = tbase + 64'(i * 16 + k);
                    b.last = (k == nb - 1);
                    tio_q[i].push_back(b);
                    b.last = (k == nb - 1) && (i == hi);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && c < 3000) begin
            @(posedge memclk);
            c++;
        end
        check_val(tag, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge memclk);
        #1;
    endtask

    task automatic drive_sources();
        s_thdr_tvalid = (hdr_q.size() != 0);
        s_thdr_tdata  = (hdr_q.size() != 0) ? hdr_q[0] : 64'd0;
        for (int i = 0; i < NT; i++) begin
            s_tio_tvalid[i]          = (tio_q[i].size() != 0);
            s_tio_tdata[i*64 +: 64]  = (tio_q[i].size() != 0) ? tio_q[i][0].d : 64'd0;
            s_tio_tlast[i]           = (tio_q[i].size() != 0) ? tio_q[i][0].last : 1'b0;
        end
    endtask

    initial begin : drv
        s_thdr_tvalid = 1'b0;
        s_thdr_tdata  = '0;
        s_tio_tvalid  = '0;
        s_tio_tdata   = '0;
        s_tio_tlast   = '0;
        m_ev_tready   = 1'b1;
        forever begin
            @(posedge memclk);
            if (memresetn) begin
                if (s_thdr_tvalid && s_thdr_tready && hdr_q.size() != 0) void'(hdr_q.pop_front());
                for (int i = 0; i < NT; i++)
                    if (s_tio_tvalid[i] && s_tio_tready[i] && tio_q[i].size() != 0) void'(tio_q[i].pop_front());
            end
            #1;
            drive_sources();
            m_ev_tready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    initial begin : mon
        beat_t e;
        forever begin
            @(posedge memclk);
            if (memresetn) begin
                if (m_ev_tvalid && m_ev_tready) begin
                    check_val("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_val("beat_data", m_ev_tdata, e.d);
                        check_val("beat_last", 64'(m_ev_tlast), 64'(e.last));
                    end
                end
                if (event_done_o) done_cnt++;
                if ($countones(s_tio_tready) > 1) oh_err++;
                if (|s_tio_tready) tio_rdy_seen++;
            end
        end
    end

    initial begin : main
        int c;
        tio_mask_i = '0;
`ifdef TURF_READOUT_TIMEOUT_EN
        timeout_i = '0;
`endif
        repeat (3) @(posedge memclk);
        #1;
        check_val("rst_ctrl", 64'({s_thdr_tready, s_tio_tready, m_ev_tvalid, m_ev_tlast, event_done_o, busy_o}), 64'd0);
        check_val("rst_data", m_ev_tdata, 64'd0);
        @(negedge memclk);
        memresetn = 1'b1;
        repeat (2) @(posedge memclk);

        // 1: all four TURFIOs, three qwords each
        d0 = done_cnt;
        send_event(64'h100, 64'hA00, 4'b0000, 3, 4'b0000);
        repeat (5) @(posedge memclk);
        #1;
        check_val("t1_busy_mid", 64'(busy_o), 64'd1);
        drain("t1_drain");
        check_val("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        check_val("t1_busy_end", 64'(busy_o), 64'd0);

        // 2: everything masked, header only
        tio_mask_i = 4'b1111;
        d0 = done_cnt;
        r0 = tio_rdy_seen;
        send_event(64'h200, 64'hA00, 4'b1111, 3, 4'b0000);
        drain("t2_drain");
        check_val("t2_tio_ready", 64'(tio_rdy_seen - r0), 64'd0);
        check_val("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 3: mask changes after the first header beat must be ignored
        tio_mask_i = 4'b0101;
        d0 = done_cnt;
        send_event(64'h300, 64'hB00, 4'b0101, 2, 4'b0000);
        c = 0;
        while (!busy_o && c < 100) begin
            @(posedge memclk);
            c++;
        end
        #1;
        tio_mask_i = 4'b0000;
        drain("t3_drain");
        check_val("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 4: back-to-back events under 30% downstream ready
        rdy_rand = 1'b1;
        tio_mask_i = 4'b0000;
        d0 = done_cnt;
        send_event(64'h400, 64'hC00, 4'b0000, 1, 4'b0000);
        send_event(64'h410, 64'hC40, 4'b0000, 4, 4'b0000);
        send_event(64'h420, 64'hC80, 4'b0000, 2, 4'b0000);
        drain("t4a_drain");
        check_val("t4a_done_cnt", 64'(done_cnt - d0), 64'd3);
        tio_mask_i = 4'b0110;
        d0 = done_cnt;
        send_event(64'h430, 64'hCC0, 4'b0110, 3, 4'b0000);
        send_event(64'h440, 64'hCE0, 4'b0110, 1, 4'b0000);
        drain("t4b_drain");
        check_val("t4b_done_cnt", 64'(done_cnt - d0), 64'd2);
        rdy_rand = 1'b0;
        repeat (2) @(posedge memclk);

        // 5: reset in the middle of TURFIO2
        tio_mask_i = 4'b0000;
        send_event(64'h500, 64'hD00, 4'b0000, 3, 4'b0000);
        c = 0;
        do begin
            @(posedge memclk);
            c++;
        end while (!(s_tio_tready[2] && s_tio_tvalid[2]) && c < 200);
        check_val("t5_reached_tio2", 64'(c < 200), 64'd1);
        @(negedge memclk);
        memresetn = 1'b0;
        #1;
        check_val("t5_rst_ctrl", 64'({s_thdr_tready, s_tio_tready, m_ev_tvalid, m_ev_tlast, event_done_o, busy_o}), 64'd0);
        check_val("t5_rst_data", m_ev_tdata, 64'd0);
        hdr_q.delete();
        exp_q.delete();
        for (int i = 0; i < NT; i++) tio_q[i].delete();
        repeat (2) @(negedge memclk);
        memresetn = 1'b1;
        repeat (2) @(posedge memclk);
        d0 = done_cnt;
        send_event(64'h600, 64'hE00, 4'b0000, 2, 4'b0000);
        drain("t5_drain");
        check_val("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

`ifdef TURF_READOUT_TIMEOUT_EN
        // 6: TURFIO1 silent, abandoned after 20 idle cycles
        timeout_i = 16'd20;
        d0 = done_cnt;
        send_event(64'h700, 64'hF00, 4'b0000, 2, 4'b0010);
        drain("t6_drain");
        check_val("t6_tio_timeout", 64'(tio_timeout_o), 64'h2);
        check_val("t6_done_cnt", 64'(done_cnt - d0), 64'd1);
        timeout_i = '0;
`endif

        check_val("onehot_ready", 64'(oh_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/turf_event_readout_ctrl.md
Name: turf_event_readout_ctrl

Overview:
- Sequences event readout in the memclk domain.
- Per event: forwards the 16-qword TURF header from the header FIFO, then drains each enabled TURFIO data stream in ascending index order.
- Emits one contiguous 64-bit AXI4-Stream event with a single tlast toward the event/DMA path.
- Owns the header-stream ready and the per-TURFIO readys. It is the only sink of the header FIFO.

Parameters:
- NUM_TIO, 4, number of TURFIO data streams.
- HDR_QWORDS, 16, header qwords per event.
- DATA_WIDTH, 64, stream width in bits.
- TIMEOUT_BITS, 16, width of stall-timeout counter (used only with the optional feature).

Ports:
- memclk  in  1  single clock for the whole block.
- memresetn  in  1  asynchronous reset, active-low.
- s_thdr_tdata  in  64  header qwords.
- s_thdr_tvalid  in  1  header valid.
- s_thdr_tready  out  1  header ready.
- s_tio_tdata  in  NUM_TIO*64  TURFIO data, stream i in bits [64i +: 64].
- s_tio_tvalid  in  NUM_TIO  per-stream valid.
- s_tio_tlast  in  NUM_TIO  per-stream end of that TURFIO's event fragment.
- s_tio_tready  out  NUM_TIO  per-stream ready; at most one bit high at any time.
- tio_mask_i  in  NUM_TIO  1 = TURFIO excluded. Sampled at the first accepted header beat.
- m_ev_tdata  out  64  event data.
- m_ev_tvalid  out  1  event valid.
- m_ev_tlast  out  1  last qword of event.
- m_ev_tready  in  1  downstream ready.
- event_done_o  out  1  one-cycle pulse when the tlast beat is accepted downstream.
- busy_o  out  1  high from the first header beat accepted until event_done_o.

Behaviour:
- Reset: all outputs 0. State IDLE, counters 0, output register empty.
- Reset asserted mid-event discards the partial event. No tlast is emitted for it.
- Output stage: 2-entry skid register.
  - One beat per cycle when m_ev_tready is held high.
  - Input-to-output latency is 1 cycle.
  - Upstream ready = skid not full AND the relevant state is active.
  - tdata and tlast hold while tvalid=1 and tready=0.
- FSM:
  - IDLE: s_thdr_tready follows skid space. On the first accepted beat, latch mask_q = tio_mask_i, set hdr_cnt = 1, go to HEADER.
  - HEADER: forward beats until hdr_cnt reaches HDR_QWORDS. On the last beat, sel = lowest unmasked index.
    - If no TURFIO is unmasked, the last header beat carries tlast and the FSM returns to IDLE.
    - Otherwise go to TIO.
  - TIO: only s_tio_tready[sel] may be high. Beats forward unchanged.
    - On an accepted beat with s_tio_tlast[sel]=1, advance sel to the next higher unmasked index.
    - If none remains, that beat carries m_ev_tlast=1 and the FSM returns to IDLE.
    - Intermediate TURFIO tlasts are not forwarded.
- Zero bubbles between header and TIO phases, or between TURFIOs.
- Changes to tio_mask_i during an event have no effect until the next event.
- A header beat while busy is not accepted: s_thdr_tready = 0 outside IDLE/HEADER.
- hdr_cnt is 5 bits (ceil log2 of HDR_QWORDS+1). It is cleared on entry to IDLE and never wraps within an event.
- event_done_o asserts in the cycle after the tlast handshake. busy_o falls in that same cycle.

Optional Feature:
- Macro: TURF_READOUT_TIMEOUT_EN.
- With the macro defined:
  - Add input timeout_i[TIMEOUT_BITS-1:0] and output tio_timeout_o[NUM_TIO], which is sticky and cleared only by reset.
  - In TIO, a counter increments each cycle that s_tio_tvalid[sel]=0 and resets on any accepted beat.
  - When the counter equals timeout_i (nonzero), the block abandons sel:
    - inject marker qword {16'hDEAD, 8'(sel), 40'h0};
    - set tio_timeout_o[sel];
    - advance as if tlast had been seen, so the marker carries m_ev_tlast if sel was the last unmasked index.
  - timeout_i = 0 disables the timeout.
- Without the macro: neither port exists and TIO waits indefinitely.

Decomposition:
- Shared package turf_readout_pkg holds:
  - state enum (IDLE, HEADER, TIO);
  - HDR_QWORDS default;
  - TIMEOUT_MARKER = 16'hDEAD;
  - function next_unmasked(mask, cur) returning index and a none flag.
- One sub-module, turf_axis_skid64, is the 2-entry output register, reusable elsewhere.

Test Plan:
1. Mask 4'b0000; header 16 qwords 0x100..0x10F; TIO0..3 each send 3 qwords (0xA00+i*16+k) with tlast on k=2.
   - Expect 28 output beats in order: header, then TIO0..3.
   - tlast only on TIO3's 3rd beat; event_done_o pulses once.
2. Mask 4'b1111: header only.
   - 16 beats, tlast on beat 16 (0x10F).
   - No s_tio_tready ever asserted.
3. Mask 4'b0101, then tio_mask_i changed to 4'b0000 after the first header beat.
   - Only TIO1 and TIO3 are drained; tlast on TIO3's last beat.
4. Random m_ev_tready at 30% duty with back-to-back events.
   - Byte-exact stream vs model; no drop or duplication.
   - s_tio_tready is one-hot or zero every cycle.
5. memresetn pulsed low during TIO2 of an event.
   - All outputs 0 immediately; next event emitted complete and correct.
6. With TURF_READOUT_TIMEOUT_EN: timeout_i=20, TIO1 silent.
   - After 20 idle cycles, marker 0xDEAD01_0000000000 emitted and tio_timeout_o=4'b0010.
   - TIO2 is drained next.
